// File: rtl/frame_level_detector_pkg.sv
// Shared types and sizing helpers for the frame level detector.
package frame_level_detector_pkg;

  typedef enum logic [1:0] {
    FLD_IDLE  = 2'd0,
    FLD_REQ   = 2'd1,
    FLD_DRAIN = 2'd2,
    FLD_DONE  = 2'd3
  } fld_state_e;

  localparam int FLD_ENERGY_W = 32;

  // Sum of FRAME_LEN squares never overflows this width.
  function automatic int fld_acc_w(input int sample_w, input int frame_len);
    return 2 * sample_w + $clog2(frame_len);
  endfunction

endpackage

// File: rtl/frame_level_detector_stat_pipe.sv
// Two-stage datapath: register sample, then abs/square into peak and energy accumulator.
module frame_stat_pipe
  import frame_level_detector_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int ACC_W    = 40
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic                sample_vld_i,
  input  logic [SAMPLE_W-1:0] sample_i,
  output logic [SAMPLE_W-1:0] peak_o,
  output logic [ACC_W-1:0]    acc_o
);

  localparam int SQ_W = 2 * SAMPLE_W - 1;

  logic [SAMPLE_W-1:0] s1_q;
  logic                s1_vld_q;
  logic [SAMPLE_W-1:0] abs_w;
  logic [SQ_W-1:0]     sq_w;
  logic [SAMPLE_W-1:0] peak_q, peak_d;
  logic [ACC_W-1:0]    acc_q, acc_d;

  // Unsigned abs keeps the most negative code representable (-32768 -> 32768).
  always_comb begin
    abs_w  = s1_q[SAMPLE_W-1] ? (~s1_q + SAMPLE_W'(1)) : s1_q;
    sq_w   = SQ_W'(abs_w) * SQ_W'(abs_w);
    peak_d = peak_q;
    acc_d  = acc_q;
    if (clear_i) begin
      peak_d = '0;
      acc_d  = '0;
    end else if (s1_vld_q) begin
      if (abs_w > peak_q) peak_d = abs_w;
      acc_d = acc_q + ACC_W'(sq_w);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q     <= '0;
      s1_vld_q <= 1'b0;
      peak_q   <= '0;
      acc_q    <= '0;
    end else begin
      if (clear_i) begin
        s1_vld_q <= 1'b0;
      end else begin
        s1_vld_q <= sample_vld_i;
        if (sample_vld_i) s1_q <= sample_i;
      end
      peak_q <= peak_d;
      acc_q  <= acc_d;
    end
  end

  assign peak_o = peak_q;
  assign acc_o  = acc_q;

endmodule

// File: rtl/frame_level_detector.sv
// Drains one half-buffer per buffer_ready_i via req/ack reads and publishes peak and mean-square.
//   state     | meaning
//   FLD_IDLE  | waiting for buffer_ready_i
//   FLD_REQ   | issuing reads, one outstanding, one idle cycle after each ack
//   FLD_DRAIN | two cycles for the stat pipeline to settle
//   FLD_DONE  | results visible, frame_valid_o high
module frame_level_detector
  import frame_level_detector_pkg::*;
#(
  parameter int FRAME_LEN   = 256,
  parameter int SAMPLE_W    = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    buffer_ready_i,
  output logic                    read_en_o,
  input  logic                    read_ack_i,
  input  logic [SAMPLE_W-1:0]     read_data_i,
  input  logic                    clear_i,
  output logic [SAMPLE_W-1:0]     peak_o,
  output logic [FLD_ENERGY_W-1:0] energy_o,
  output logic                    frame_valid_o,
  output logic                    busy_o,
  output logic                    overrun_o,
  output logic                    timeout_o
);

  localparam int LEN_LOG2 = $clog2(FRAME_LEN);
  localparam int ACC_W    = fld_acc_w(SAMPLE_W, FRAME_LEN);
  localparam int CNT_W    = LEN_LOG2 + 1;
  localparam int TO_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0]  TO_LOAD  = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

  fld_state_e state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [TO_W-1:0]         to_q, to_d;
  logic                    gap_q, gap_d;
  logic                    drain_q, drain_d;
  logic                    ovr_q, ovr_d, tmo_q, tmo_d;
  logic [SAMPLE_W-1:0]     peak_out_q;
  logic [FLD_ENERGY_W-1:0] energy_out_q;
  logic                    req_w, start_w, publish_w, set_to_w, ack_fire_w;
  logic [SAMPLE_W-1:0]     pipe_peak_w;
  logic [ACC_W-1:0]        pipe_acc_w, mean_w;
  logic [FLD_ENERGY_W-1:0] energy_w;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    to_d      = to_q;
    gap_d     = 1'b0;
    drain_d   = drain_q;
    start_w   = 1'b0;
    publish_w = 1'b0;
    set_to_w  = 1'b0;
    req_w     = 1'b0;
    case (state_q)
      FLD_IDLE: begin
        if (buffer_ready_i) begin
          start_w = 1'b1;
          cnt_d   = '0;
          to_d    = TO_LOAD;
          drain_d = 1'b0;
          state_d = FLD_REQ;
        end
      end
      FLD_REQ: begin
        req_w = ~gap_q;
        if (req_w && read_ack_i) begin
          cnt_d = cnt_q + CNT_W'(1);
          to_d  = TO_LOAD;
          gap_d = 1'b1;
          if (cnt_q == CNT_LAST) state_d = FLD_DRAIN;
        end else if (req_w) begin
          // Terminal count of the ack timer aborts the frame without publishing.
          if (to_q == '0) begin
            set_to_w = 1'b1;
            state_d  = FLD_IDLE;
          end else begin
            to_d = to_q - TO_W'(1);
          end
        end
      end
      FLD_DRAIN: begin
        if (drain_q) begin
          publish_w = 1'b1;
          state_d   = FLD_DONE;
        end else begin
          drain_d = 1'b1;
        end
      end
      FLD_DONE: state_d = FLD_IDLE;
      default:  state_d = FLD_IDLE;
    endcase
  end

  assign ack_fire_w = req_w & read_ack_i;

  // A clear wins over a same-cycle set.
  always_comb begin
    ovr_d = clear_i ? 1'b0 : (ovr_q | (buffer_ready_i & (state_q != FLD_IDLE)));
    tmo_d = clear_i ? 1'b0 : (tmo_q | set_to_w);
  end

  frame_stat_pipe #(
    .SAMPLE_W(SAMPLE_W),
    .ACC_W   (ACC_W)
  ) u_stat_pipe (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (start_w),
    .sample_vld_i(ack_fire_w),
    .sample_i    (read_data_i),
    .peak_o      (pipe_peak_w),
    .acc_o       (pipe_acc_w)
  );

  assign mean_w = pipe_acc_w >> LEN_LOG2;

  if (ACC_W > FLD_ENERGY_W) begin : g_sat
    assign energy_w = (|mean_w[ACC_W-1:FLD_ENERGY_W]) ? '1 : mean_w[FLD_ENERGY_W-1:0];
  end else begin : g_nosat
    assign energy_w = FLD_ENERGY_W'(mean_w);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= FLD_IDLE;
      cnt_q        <= '0;
      to_q         <= '0;
      gap_q        <= 1'b0;
      drain_q      <= 1'b0;
      ovr_q        <= 1'b0;
      tmo_q        <= 1'b0;
      peak_out_q   <= '0;
      energy_out_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      gap_q   <= gap_d;
      drain_q <= drain_d;
      ovr_q   <= ovr_d;
      tmo_q   <= tmo_d;
      if (publish_w) begin
        peak_out_q   <= pipe_peak_w;
        energy_out_q <= energy_w;
      end
    end
  end

  assign read_en_o     = req_w;
  assign peak_o        = peak_out_q;
  assign energy_o      = energy_out_q;
  assign frame_valid_o = (state_q == FLD_DONE);
  assign busy_o        = (state_q != FLD_IDLE);
  assign overrun_o     = ovr_q;
  assign timeout_o     = tmo_q;

endmodule

// File: doc/frame_level_detector.md
Name: frame_level_detector

Overview:
- Downstream consumer of the ping-pong sample RAM.
- When a half-buffer is reported full, drains FRAME_LEN 16-bit signed samples through a request/acknowledge read handshake.
- Computes per-frame peak absolute value and mean-square energy; publishes both with a one-cycle valid strobe.
- Drives the VU/debug path and any later frame-based processing (e.g. DOA) with one result per buffer.

Parameters:
- FRAME_LEN, 256, samples per half-buffer; power of two, 4..4096.
- SAMPLE_W, 16, signed sample width from RAM.
- TIMEOUT_CYC, 1024, max cycles read_en_o may wait for read_ack_i before the frame aborts.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- buffer_ready_i  in  1  one-cycle pulse: a half-buffer is full and readable.
- read_en_o  out  1  read request; held high until acknowledged.
- read_ack_i  in  1  read_data_i valid this cycle; completes the request.
- read_data_i  in  SAMPLE_W  signed sample from RAM.
- clear_i  in  1  synchronous clear of sticky error flags.
- peak_o  out  SAMPLE_W  unsigned max |sample| of last completed frame.
- energy_o  out  32  mean-square of last completed frame.
- frame_valid_o  out  1  one-cycle pulse when peak_o/energy_o update.
- busy_o  out  1  high while a frame is being read.
- overrun_o  out  1  sticky: buffer_ready_i arrived while busy.
- timeout_o  out  1  sticky: a frame aborted on ack timeout.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; counters and accumulators 0.
- FSM states: IDLE, REQ, DRAIN, DONE.
- IDLE: on buffer_ready_i, clear the accumulator, peak register, sample counter and timeout counter, then go to REQ.
- REQ:
  - read_en_o = 1; at most one outstanding request.
  - On read_ack_i: capture the sample; sample counter +1.
  - read_en_o deasserts for exactly the cycle after each ack. The next request starts one cycle later, so the maximum rate is one sample per 2 cycles.
  - On the ack that brings the counter to FRAME_LEN, go to DRAIN. read_en_o drops and is not re-raised.
- Datapath pipeline:
  - Stage 1 registers the captured sample.
  - Stage 2 computes abs (unsigned SAMPLE_W bits; -32768 -> 32768) and square (2*SAMPLE_W-1 bits unsigned).
  - It then updates the peak (strict > compare) and the accumulator.
  - Accumulator width = 2*SAMPLE_W + log2(FRAME_LEN) (40 bits at defaults); it never saturates.
- DRAIN: waits 2 cycles for the pipeline to flush, then goes to DONE.
- DONE (1 cycle):
  - peak_o <= peak register.
  - energy_o <= accumulator >> log2(FRAME_LEN). If the result exceeds 32 bits, saturate to 0xFFFF_FFFF; otherwise take the low 32 bits.
  - frame_valid_o = 1; return to IDLE.
- Latency: frame_valid_o asserts 3 cycles after the final read_ack_i.
- busy_o = 1 in REQ, DRAIN and DONE.
- Overrun: buffer_ready_i while not in IDLE sets overrun_o. The current frame continues unaffected and the pulse is discarded.
- buffer_ready_i in the same cycle DONE exits counts as an overrun (not IDLE yet).
- Timeout:
  - The counter runs while read_en_o = 1 without an ack and resets on each ack.
  - On reaching TIMEOUT_CYC: set timeout_o, drop read_en_o, discard partial results, return to IDLE.
  - No frame_valid_o; peak_o/energy_o keep previous values.
- read_ack_i while read_en_o = 0 is ignored.
- clear_i clears overrun_o/timeout_o.
  - clear_i has priority in the same cycle as a new set: the flag stays set only if the set condition also occurs on the next cycle.
- Reset asserted mid-frame: immediate return to reset values. No partial frame is ever published.

Decomposition:
- fpga_template_pkg gets:
  - typedef enum for FSM states (FLD_IDLE, FLD_REQ, FLD_DRAIN, FLD_DONE);
  - localparam FLD_ENERGY_W = 32;
  - function clog2-based ACC_W helper.
- One sub-module: frame_stat_pipe, the 2-stage abs/square/peak/accumulate datapath.
  - Inputs: sample and valid strobe, plus a clear.
  - Outputs: peak and accumulator.
- The FSM and handshake stay in the top module.

Test Plan:
- FRAME_LEN=4; samples 100, -200, 300, -400; ack 1 cycle after each request.
  -> peak_o=400, energy_o=(10000+40000+90000+160000)/4=75000, frame_valid_o exactly one pulse 3 cycles after the 4th ack.
- Frame of all -32768 (FRAME_LEN=256) -> peak_o=32768, energy_o=0x4000_0000, no saturation.
- Ack stalled for 1024 cycles on sample 10 (TIMEOUT_CYC=1024).
  -> read_en_o drops, timeout_o=1, no frame_valid_o, prior peak_o/energy_o unchanged.
  -> Next buffer_ready_i then processes a full frame normally.
- buffer_ready_i pulsed mid-frame -> overrun_o=1, frame still completes with correct results.
  -> clear_i then returns overrun_o to 0.
- rst_ni asserted asynchronously after 100 of 256 acks.
  -> All outputs 0 immediately, no frame_valid_o.
  -> After release, a new frame gives correct results.
- Back-to-back frames with acks in the same cycle as each request.
  -> read_en_o shows a 1-on/1-off pattern.
  -> Two frame_valid_o pulses, each with independent values; no carry-over of peak or accumulator.
